// File: rtl/ssd_pkg.sv
// Shared types and constants for the keypad entry / two-digit SSD multiplexer.
package ssd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } entry_state_t;

    typedef logic [3:0] digit_t;

    localparam logic CSEL_RIGHT = 1'b0;
    localparam logic CSEL_LEFT  = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_entry_mux_if.sv
// Keypad-side inputs and display-side outputs of keypad_entry_mux.
interface keypad_entry_mux_if;
    import ssd_pkg::*;

    digit_t     key_code;
    logic       key_valid;
    logic       clr;
    digit_t     disp_val;
    logic       disp_blank;
    logic       chip_sel;
    logic       key_event;
    logic [1:0] digit_cnt;

    modport master (
        output key_code, key_valid, clr,
        input  disp_val, disp_blank, chip_sel, key_event, digit_cnt
    );

    modport slave (
        input  key_code, key_valid, clr,
        output disp_val, disp_blank, chip_sel, key_event, digit_cnt
    );

endinterface

// File: rtl/ssd_refresh_timer.sv
// Free-running digit refresh timer: toggles chip_sel every HALF_CYCLES clocks.
module ssd_refresh_timer
    import ssd_pkg::*;
#(
    parameter int HALF_CYCLES = 10,
    parameter int CNT_W       = $clog2(HALF_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    output logic chip_sel
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             chip_sel_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg      <= '0;
            chip_sel_reg <= CSEL_RIGHT;
        end else if (cnt_reg == HALF_LAST) begin
            cnt_reg      <= '0;
            chip_sel_reg <= ~chip_sel_reg;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign chip_sel = chip_sel_reg;

endmodule

// File: rtl/keypad_entry_mux.sv
// Debounced keypad press qualification, two-digit entry shift register and
// time-multiplexed output onto the shared seven-segment bus.
module keypad_entry_mux
    import ssd_pkg::*;
#(
    parameter int clk_freq    = 125_000_000,
    parameter int stable_time = 10,
    parameter int refresh_hz  = 100
) (
    input  logic               clk,
    input  logic               rst,
    keypad_entry_mux_if.slave  bus
);

    localparam int STABLE_CYCLES = clk_freq / 1000 * stable_time;
    localparam int HALF_CYCLES   = clk_freq / (2 * refresh_hz);
    localparam int CNT_RAW       = $clog2(max_int(STABLE_CYCLES, HALF_CYCLES));
    localparam int CNT_W         = (CNT_RAW < 1) ? 1 : CNT_RAW;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || HALF_CYCLES < 2) begin : g_param_check
        $error("keypad_entry_mux: STABLE_CYCLES and HALF_CYCLES must both be >= 2");
    end

    entry_state_t     state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    digit_t           cand_reg, cand_next;
    logic             accept;
    logic             arm_reg;
    logic             key_event_reg;
    digit_t           left_reg, right_reg;
    logic [1:0]       digit_cnt_reg;
    digit_t           disp_val_reg;
    logic             disp_blank_reg;
    logic             chip_sel;

    ssd_refresh_timer #(
        .HALF_CYCLES (HALF_CYCLES),
        .CNT_W       (CNT_W)
    ) u_refresh (
        .clk      (clk),
        .rst      (rst),
        .chip_sel (chip_sel)
    );

    // A key already held when reset releases must be let go before it can
    // start a new press; arm_reg records that key_valid has been seen low.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cand_next  = cand_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.key_valid && arm_reg) begin
                    state_next = PRESS_WAIT;
                    cand_next  = bus.key_code;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!bus.key_valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (bus.key_code != cand_reg) begin
                    cand_next = bus.key_code;
                    cnt_next  = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    accept     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            HELD: begin
                if (!bus.key_valid) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (bus.key_valid) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == STABLE_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            cand_reg       <= '0;
            arm_reg        <= 1'b0;
            key_event_reg  <= 1'b0;
            left_reg       <= '0;
            right_reg      <= '0;
            digit_cnt_reg  <= '0;
            disp_val_reg   <= '0;
            disp_blank_reg <= 1'b1;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            cand_reg      <= cand_next;
            key_event_reg <= accept;
            if (!bus.key_valid) begin
                arm_reg <= 1'b1;
            end
            // clr has priority over a simultaneous accept; the event still pulses
            if (bus.clr) begin
                left_reg      <= '0;
                right_reg     <= '0;
                digit_cnt_reg <= '0;
            end else if (accept) begin
                left_reg      <= right_reg;
                right_reg     <= cand_reg;
                digit_cnt_reg <= (digit_cnt_reg == 2'd2) ? 2'd2 : digit_cnt_reg + 2'd1;
            end
            disp_val_reg   <= (chip_sel == CSEL_LEFT) ? left_reg : right_reg;
            disp_blank_reg <= (chip_sel == CSEL_LEFT) ? (digit_cnt_reg < 2'd2)
                                                      : (digit_cnt_reg == 2'd0);
        end
    end

    assign bus.disp_val   = disp_val_reg;
    assign bus.disp_blank = disp_blank_reg;
    assign bus.chip_sel   = chip_sel;
    assign bus.key_event  = key_event_reg;
    assign bus.digit_cnt  = digit_cnt_reg;

endmodule
